// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
//   Bundles the instruction handshake, the ALU-facing operand/result bus and
//   the debug register-file read port of the ALU sequencer.
//
//   Instruction side : ivalid, oready, iop, ird, irs1, irs2
//   ALU side         : oin1, oin2, oiop (to ALU); ialu_out, iPSR (from ALU)
//   Status side      : oPSR, odone, oillegal
//   Debug side       : iraddr, ordata
//
//   The "slave" modport is the sequencer itself; "master" is the environment
//   (instruction source, ALU and debug reader) that talks to it.
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int Bits = 12,
    parameter int Ops  = 4,
    parameter int Regs = 8,
    parameter int RA   = $clog2(Regs)
);
    logic            ivalid;
    logic            oready;
    logic [Ops-1:0]  iop;
    logic [RA-1:0]   ird;
    logic [RA-1:0]   irs1;
    logic [RA-1:0]   irs2;
    logic [Bits-1:0] oin1;
    logic [Bits-1:0] oin2;
    logic [Ops-1:0]  oiop;
    logic [Bits-1:0] ialu_out;
    logic [4:0]      iPSR;
    logic [4:0]      oPSR;
    logic            odone;
    logic            oillegal;
    logic [RA-1:0]   iraddr;
    logic [Bits-1:0] ordata;

    modport slave (
        input  ivalid, iop, ird, irs1, irs2, ialu_out, iPSR, iraddr,
        output oready, oin1, oin2, oiop, oPSR, odone, oillegal, ordata
    );

    modport master (
        output ivalid, iop, ird, irs1, irs2, ialu_out, iPSR, iraddr,
        input  oready, oin1, oin2, oiop, oPSR, odone, oillegal, ordata
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Issue/writeback controller wrapped around a registered 12-bit ALU.
//   Accepts one instruction at a time, reads both operands from an internal
//   register file at accept, drives the ALU for exactly one cycle, then
//   captures the ALU result and flags, writing the result back to rd and the
//   flags to the architectural status register.
//
//   Ports:
//     iclock  - single clock shared with the ALU
//     ireset  - synchronous, active-high reset (also clears the register file)
//     bus     - alu_sequencer_if.slave: instruction handshake, ALU operand/
//               opcode outputs, ALU result/flag inputs, oPSR/odone/oillegal
//               status outputs and the combinational debug read port
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int Bits = 12,
    parameter int Ops  = 4,
    parameter int Regs = 8
) (
    input  logic           iclock,
    input  logic           ireset,
    alu_sequencer_if.slave bus
);
    localparam int RA = $clog2(Regs);

    localparam logic [Ops-1:0] OP_ADD  = 4'b0100;
    localparam logic [Ops-1:0] OP_MUL  = 4'b0101;
    localparam logic [Ops-1:0] OP_CMP  = 4'b0110;
    localparam logic [Ops-1:0] OP_SHF  = 4'b0111;
    localparam logic [Ops-1:0] OP_ROT  = 4'b1000;
    // The ALU does not decode this value, so it simply holds its last result.
    localparam logic [Ops-1:0] OP_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t          state_q, state_d;
    logic [Ops-1:0]  op_q;
    logic [RA-1:0]   rd_q;
    logic [Bits-1:0] operandA_q;
    logic [Bits-1:0] operandB_q;
    logic [Bits-1:0] rf_q [Regs];
    logic [4:0]      psr_q;
    logic            done_q;
    logic            illegal_q;

    logic            readyInt;
    logic            legalOp;
    logic            accept;

    assign legalOp = (bus.iop == OP_ADD) || (bus.iop == OP_MUL) ||
                     (bus.iop == OP_CMP) || (bus.iop == OP_SHF) ||
                     (bus.iop == OP_ROT);
    assign accept  = bus.ivalid && readyInt;

    // State register.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed three-cycle walk once a legal opcode is taken;
    // illegal opcodes never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && legalOp) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the ALU only sees a real opcode during ISSUE; oready is
    // forced low while reset is held.
    always_comb begin
        readyInt = 1'b0;
        bus.oin1 = '0;
        bus.oin2 = '0;
        bus.oiop = OP_NONE;
        case (state_q)
            IDLE:  readyInt = !ireset;
            ISSUE: begin
                bus.oin1 = operandA_q;
                bus.oin2 = operandB_q;
                bus.oiop = op_q;
            end
            default: ;
        endcase
    end

    // Datapath: operands are sampled from the register file at accept, so
    // they see the pre-edge contents even if rs == rd. Writeback, flag update
    // and the done pulse all land on the edge that leaves CAPTURE.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            op_q       <= OP_NONE;
            rd_q       <= '0;
            operandA_q <= '0;
            operandB_q <= '0;
            psr_q      <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < Regs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            illegal_q <= accept && !legalOp;
            if (accept && legalOp) begin
                op_q       <= bus.iop;
                rd_q       <= bus.ird;
                operandA_q <= rf_q[bus.irs1];
                operandB_q <= rf_q[bus.irs2];
            end
            if (state_q == CAPTURE) begin
                rf_q[rd_q] <= bus.ialu_out;
                psr_q      <= bus.iPSR;
                done_q     <= 1'b1;
            end
        end
    end

    assign bus.oready   = readyInt;
    assign bus.oPSR     = psr_q;
    assign bus.odone    = done_q;
    assign bus.oillegal = illegal_q;
    assign bus.ordata   = rf_q[bus.iraddr];
endmodule
